dfndr_dl_router: RTL and testbench

//  Sits between hps_io and the defender core; sole single-clock owner of the MRA download stream.

---
 rtl/dfndr_dl_router.sv | 118 +++++++++++
 tb/tb_dfndr_dl_router.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dfndr_dl_router.sv
// dfndr_dl_router: routes download writes to the ROM port, mod register and DIP bank, and sequences core reset
module dfndr_dl_router #(
  parameter int ROM_AW      = 16,
  parameter int ROM_INDEX   = 0,
  parameter int MOD_INDEX   = 1,
  parameter int DIP_INDEX   = 254,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              dn_ready,
  output logic [ROM_AW-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic [7:0]        mod,
  output logic [63:0]       dip_bus,
  output logic              core_reset,
  output logic              dl_done,
  output logic [ROM_AW:0]   rom_count,
  output logic [15:0]       rom_sum,
  output logic [1:0]        err
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [7:0] ROM_IDX = 8'(ROM_INDEX);
  localparam logic [7:0] MOD_IDX = 8'(MOD_INDEX);
  localparam logic [7:0] DIP_IDX = 8'(DIP_INDEX);
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD_CYCLES - 1);
  localparam logic [ROM_AW:0] CNT_MAX = {1'b1, {ROM_AW{1'b0}}};
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic buf_valid_q;
  logic [ROM_AW-1:0] buf_addr_q;
  logic [7:0] buf_data_q;
  logic core_reset_d, rom_wr, in_range, accept, drain, start;
  assign ioctl_wait = buf_valid_q;
  assign in_range = (ioctl_addr >> ROM_AW) == 25'd0;
  assign rom_wr = ioctl_wr && ioctl_index == ROM_IDX && state_q == LOAD;
  assign accept = rom_wr && in_range && !buf_valid_q;
  assign drain = buf_valid_q && dn_ready;
  assign start = state_q == IDLE && state_d == LOAD;
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q <= CNT_INIT;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (ioctl_download && ioctl_index == ROM_IDX) ? LOAD : IDLE;
      LOAD:    state_d = ioctl_download ? LOAD : buf_valid_q ? DRAIN : HOLD;
      DRAIN:   state_d = buf_valid_q ? DRAIN : HOLD;
      default: state_d = (cnt_q == '0) ? IDLE : HOLD;
    endcase
  end
  always_comb begin
    cnt_d = (state_q == HOLD) ? cnt_q - CW'(1) : CNT_INIT;
    core_reset_d = state_d != IDLE || state_q != IDLE;
  end
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      core_reset <= 1'b1;
      dl_done <= 1'b0;
    end else begin
      core_reset <= core_reset_d;
      dl_done <= core_reset && !core_reset_d;
    end
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      buf_valid_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      dn_wr <= 1'b0;
      dn_addr <= '0;
      dn_data <= '0;
    end else begin
      buf_valid_q <= accept || (buf_valid_q && !dn_ready);
      if (accept) begin
        buf_addr_q <= ioctl_addr[ROM_AW-1:0];
        buf_data_q <= ioctl_dout;
      end
      dn_wr <= drain;
      if (drain) begin
        dn_addr <= buf_addr_q;
        dn_data <= buf_data_q;
      end
    end
  always_ff @(posedge clk_sys)
    if (!reset_n || start) begin
      rom_count <= '0;
      rom_sum <= '0;
      err <= '0;
    end else begin
      if (accept) begin
        rom_sum <= rom_sum + {8'd0, ioctl_dout};
        if (rom_count != CNT_MAX) rom_count <= rom_count + (ROM_AW + 1)'(1);
      end
      err <= err | {rom_wr && !in_range, rom_wr && in_range && buf_valid_q};
    end
  always_ff @(posedge clk_sys)
    if (!reset_n) begin
      mod <= '0;
      dip_bus <= '0;
    end else begin
      if (ioctl_wr && ioctl_index == MOD_IDX) mod <= ioctl_dout;
      if (ioctl_wr && ioctl_index == DIP_IDX && ioctl_addr[24:3] == '0)
        dip_bus[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
endmodule

// File: tb/tb_dfndr_dl_router.sv
// tb_dfndr_dl_router: randomized scoreboard bench for the download router
module tb_dfndr_dl_router;
  localparam int HOLD = 16;
  logic clk_sys = 0, reset_n = 0, ioctl_download = 0, ioctl_wr = 0, dn_ready = 1;
  logic [7:0] ioctl_index = 0, ioctl_dout = 0;
  logic [24:0] ioctl_addr = 0;
  logic ioctl_wait, dn_wr, core_reset, dl_done;
  logic [15:0] dn_addr, rom_sum;
  logic [7:0] dn_data, mod;
  logic [63:0] dip_bus;
  logic [16:0] rom_count;
  logic [1:0] err;
  int n_vec = 0, n_err = 0;
  logic [23:0] exp_q[$];
  int m_count = 0;
  logic [15:0] m_sum = 0;
  logic [1:0] m_err = 0;
  logic [7:0] m_dip[8];
  logic [7:0] m_mod = 0;
  bit rand_rdy = 0;

  dfndr_dl_router dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .dn_ready(dn_ready),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .mod(mod), .dip_bus(dip_bus),
    .core_reset(core_reset), .dl_done(dl_done), .rom_count(rom_count),
    .rom_sum(rom_sum), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_sys) if (rand_rdy) dn_ready = 1'($urandom_range(0, 1));

  always @(negedge clk_sys)
    if (reset_n && dn_wr) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dn_write: got %h:%h expected no write", dn_addr, dn_data);
      end else chk("dn_write", 64'({dn_addr, dn_data}), 64'(exp_q.pop_front()));
    end

  task automatic wr_rom(input logic [24:0] a, input logic [7:0] d, output int w);
    ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    if (a < 25'h10000) begin
      exp_q.push_back({a[15:0], d});
      m_count++;
      m_sum += 16'(d);
    end else m_err[1] = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 0;
    w = 0;
    while (ioctl_wait && w < 1000) begin
      w++;
      @(negedge clk_sys);
    end
    if (w >= 1000) chk("wait_release", 64'(ioctl_wait), 64'd0);
  endtask

  task automatic wr_pulse(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    ioctl_index = idx; ioctl_wr = 1; ioctl_addr = a; ioctl_dout = d;
    if (idx == 8'd1) m_mod = d;
    if (idx == 8'd254 && a < 25'd8) m_dip[a[2:0]] = d;
    @(negedge clk_sys);
    ioctl_wr = 0;
    chk("side_no_wait", 64'(ioctl_wait), 64'd0);
    chk("side_core_reset", 64'(core_reset), 64'd0);
  endtask

  task automatic start_dl();
    ioctl_index = 0;
    ioctl_download = 1;
    @(negedge clk_sys);
    m_count = 0; m_sum = 0; m_err = 0;
    chk("load_core_reset", 64'(core_reset), 64'd1);
  endtask

  task automatic end_dl();
    int t = 0;
    ioctl_download = 0;
    while (!dl_done && t < 300) begin
      t++;
      @(negedge clk_sys);
    end
    chk("dl_done_seen", 64'(dl_done), 64'd1);
    chk("core_reset_off", 64'(core_reset), 64'd0);
    chk("rom_count", 64'(rom_count), 64'(m_count));
    chk("rom_sum", 64'(rom_sum), 64'(m_sum));
    chk("err", 64'(err), 64'(m_err));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] dip_model();
    logic [63:0] r = '0;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = m_dip[k];
    return r;
  endfunction

  initial begin
    int c, w, n;
    logic [24:0] a;
    logic [7:0] t2[4];
    t2 = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int k = 0; k < 8; k++) m_dip[k] = 8'd0;
    repeat (3) @(negedge clk_sys);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_dn_wr", 64'(dn_wr), 64'd0);
    chk("rst_wait", 64'(ioctl_wait), 64'd0);
    chk("rst_dn_bus", 64'({dn_addr, dn_data}), 64'd0);
    chk("rst_counts", 64'({rom_count, rom_sum, err}), 64'd0);
    chk("rst_mod_dl_done", 64'({mod, dl_done}), 64'd0);
    chk("rst_dip", dip_bus, 64'd0);
    c = 1;
    reset_n = 1;
    @(negedge clk_sys);
    while (core_reset && c < 100) begin
      c++;
      @(negedge clk_sys);
    end
    chk("reset_hold_cycles", 64'(c), 64'(HOLD + 1));
    chk("dl_done_pulse", 64'(dl_done), 64'd1);
    @(negedge clk_sys);
    chk("dl_done_single", 64'(dl_done), 64'd0);

    start_dl();
    for (int i = 0; i < 4; i++) begin
      wr_rom(25'(i), t2[i], w);
      chk("wait_one_cycle", 64'(w), 64'd1);
    end
    end_dl();
    chk("sum_aa", 64'(rom_sum), 64'h00AA);

    dn_ready = 0;
    start_dl();
    ioctl_wr = 1; ioctl_addr = 0; ioctl_dout = 8'hA5;
    exp_q.push_back({16'h0000, 8'hA5});
    m_count++;
    m_sum += 16'h00A5;
    m_err[0] = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 10; i++) begin
      chk("stall_wait", 64'(ioctl_wait), 64'd1);
      chk("stall_no_wr", 64'(dn_wr), 64'd0);
      ioctl_wr = (i == 3); ioctl_addr = 25'd1; ioctl_dout = 8'h5A;
      @(negedge clk_sys);
    end
    dn_ready = 1;
    @(negedge clk_sys);
    chk("ready_rise_wr", 64'(dn_wr), 64'd1);
    @(negedge clk_sys);
    chk("ready_rise_wait", 64'(ioctl_wait), 64'd0);
    end_dl();

    start_dl();
    wr_rom(25'd5, 8'h77, w);
    wr_rom(25'h10000, 8'h99, w);
    chk("oor_no_wait", 64'(w), 64'd0);
    chk("oor_count", 64'(rom_count), 64'd1);
    chk("oor_err", 64'(err), 64'd2);
    end_dl();

    ioctl_download = 1;
    wr_pulse(8'd254, 25'd0, 8'h01);
    wr_pulse(8'd254, 25'd1, 8'h02);
    wr_pulse(8'd254, 25'd2, 8'h03);
    wr_pulse(8'd254, 25'd8, 8'hFF);
    chk("dip_bytes", dip_bus, 64'h0000_0000_0003_0201);
    wr_pulse(8'd1, 25'($urandom_range(0, 1000)), 8'h02);
    chk("mod_value", 64'(mod), 64'd2);
    for (int i = 0; i < 8; i++)
      wr_pulse(8'd254, 25'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    wr_pulse(8'd1, 25'd3, 8'($urandom_range(0, 255)));
    chk("dip_random", dip_bus, dip_model());
    chk("mod_random", 64'(mod), 64'(m_mod));
    chk("side_err_kept", 64'(err), 64'(m_err));
    chk("side_count_kept", 64'(rom_count), 64'(m_count));
    ioctl_download = 0;
    @(negedge clk_sys);

    rand_rdy = 1;
    repeat (4) begin
      start_dl();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        a = ($urandom_range(0, 7) == 0) ? 25'h10000 + 25'($urandom_range(0, 255))
                                        : 25'($urandom_range(0, 65535));
        wr_rom(a, 8'($urandom_range(0, 255)), w);
      end
      end_dl();
    end
    rand_rdy = 0;
    dn_ready = 1;
    @(negedge clk_sys);

    start_dl();
    dn_ready = 0;
    ioctl_wr = 1; ioctl_addr = 25'd7; ioctl_dout = 8'h42;
    @(negedge clk_sys);
    ioctl_wr = 0;
    chk("pre_reset_wait", 64'(ioctl_wait), 64'd1);
    reset_n = 0;
    @(negedge clk_sys);
    chk("midrst_wait", 64'(ioctl_wait), 64'd0);
    chk("midrst_dn_wr", 64'(dn_wr), 64'd0);
    chk("midrst_counts", 64'({rom_count, rom_sum, err}), 64'd0);
    chk("midrst_core_reset", 64'(core_reset), 64'd1);
    reset_n = 1;
    dn_ready = 1;
    repeat (3) @(negedge clk_sys);
    m_count = 0; m_sum = 0; m_err = 0;
    end_dl();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
